// File: rtl/dmem_arb_if.sv
// -----------------------------------------------------------------------------
// dmem_arb_if
// This interface bundles the request, response and memory-side signals of the
// data-memory arbiter.
//
// Modports
//   slave  : the arbiter's view.
//            - Inputs: the requests and the memory read data.
//            - Outputs: accept, response and memory commands.
//   master : the environment's view (requesters plus memory). It mirrors slave.
//
// Signals
//   req_valid/req_ready/req_we        2-bit per-port handshake (bit i = port i)
//   req_addr                          port i at [i*ADDR_W +: ADDR_W]
//   req_funct3                        port i at [3i +: 3]
//   req_wdata                         port i at [i*XLEN +: XLEN], little-endian
//   rsp_valid/rsp_data/rsp_err        one-hot response strobe, load data, error
//   mem_wr_en/addr/data/len           write port, byte at addr = data[7:0]
//   mem_rd_en/addr, mem_rd_data       read port; data arrives one cycle later
//                                     with byte addr+k at [XLEN-1-8k -: 8]
// -----------------------------------------------------------------------------
interface dmem_arb_if #(
    parameter int ADDR_W = 11,
    parameter int XLEN   = 64
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [5:0]          req_funct3;
    logic [2*XLEN-1:0]   req_wdata;
    logic [1:0]          rsp_valid;
    logic [XLEN-1:0]     rsp_data;
    logic                rsp_err;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [XLEN-1:0]     mem_wr_data;
    logic [3:0]          mem_wr_len;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic [XLEN-1:0]     mem_rd_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, mem_rd_data,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_len,
               mem_rd_en, mem_rd_addr
    );

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, mem_rd_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_len,
               mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/dmem_arb_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_arb_ctrl
// This block is a load/store sequencer and a two-port round-robin arbiter. It
// sits in front of a byte-addressed data memory.
//   - Port 0 is the core MEM stage.
//   - Port 1 is the program/data loader.
//
// Each accepted request follows the same timing:
//   - It is captured in IDLE.
//   - It performs one memory access (ISSUE), or it skips the access when the
//     request is illegal or misaligned (ERR).
//   - It returns a one-cycle, one-hot response (RESP).
//
// Ports
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : dmem_arb_if.slave, which carries the request, response and memory
//          signals
// -----------------------------------------------------------------------------
module dmem_arb_ctrl #(
    parameter int ADDR_W = 11,
    parameter int XLEN   = 64
) (
    input  logic       clk,
    input  logic       rst,
    dmem_arb_if.slave  bus
);
    localparam int NBYTES = XLEN / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, ERR, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q;
    logic                cmd_port_q;
    logic                cmd_we_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic [2:0]          cmd_f3_q;
    logic [XLEN-1:0]     cmd_wdata_q;
    logic                cmd_err_q;

    // Unpack the per-port request fields into arrays indexed by port.
    logic [ADDR_W-1:0]   port_addr  [2];
    logic [2:0]          port_f3    [2];
    logic [XLEN-1:0]     port_wdata [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign port_addr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign port_f3[gi]    = bus.req_funct3[gi*3 +: 3];
        assign port_wdata[gi] = bus.req_wdata[gi*XLEN +: XLEN];
    end

    // Arbitration. When both ports request, the port not served last wins.
    logic grant;
    logic handshake;
    assign grant     = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
    // Reset also blocks acceptance, so that req_ready is low while rst is high.
    assign handshake = (state_q == IDLE) && (|bus.req_valid) && !rst;
    assign bus.req_ready = handshake ? (grant ? 2'b10 : 2'b01) : 2'b00;

    // Check the legality and natural alignment of the granted request.
    logic              sel_we;
    logic [2:0]        sel_f3;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        size_mask;
    logic              sel_illegal;
    logic              sel_misaligned;

    assign sel_we   = bus.req_we[grant];
    assign sel_f3   = port_f3[grant];
    assign sel_addr = port_addr[grant];

    always_comb begin
        size_mask = 3'b000;
        case (sel_f3[1:0])
            2'b00:   size_mask = 3'b000;
            2'b01:   size_mask = 3'b001;
            2'b10:   size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    end

    // Stores have no unsigned forms. For loads, only unsigned D (111) is undefined.
    assign sel_illegal    = sel_we ? sel_f3[2] : (sel_f3 == 3'b111);
    assign sel_misaligned = (sel_addr[2:0] & size_mask) != 3'b000;

    // State and command registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cmd_port_q   <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_f3_q     <= 3'b000;
            cmd_wdata_q  <= '0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                cmd_port_q   <= grant;
                cmd_we_q     <= sel_we;
                cmd_addr_q   <= sel_addr;
                cmd_f3_q     <= sel_f3;
                cmd_wdata_q  <= port_wdata[grant];
                cmd_err_q    <= sel_illegal || sel_misaligned;
                last_grant_q <= grant;
            end
        end
    end

    // Reorder the memory bytes (byte addr+k sits at the top) into a
    // little-endian word.
    logic [XLEN-1:0] rd_le;
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_swap
        assign rd_le[8*gi +: 8] = bus.mem_rd_data[XLEN-1-8*gi -: 8];
    end

    logic [XLEN-1:0] load_val;
    always_comb begin
        load_val = '0;
        case (cmd_f3_q)
            3'b000:  load_val = {{(XLEN-8){rd_le[7]}},   rd_le[7:0]};
            3'b001:  load_val = {{(XLEN-16){rd_le[15]}}, rd_le[15:0]};
            3'b010:  load_val = {{(XLEN-32){rd_le[31]}}, rd_le[31:0]};
            3'b011:  load_val = rd_le;
            3'b100:  load_val = {{(XLEN-8){1'b0}},  rd_le[7:0]};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, rd_le[15:0]};
            3'b110:  load_val = {{(XLEN-32){1'b0}}, rd_le[31:0]};
            default: load_val = '0;
        endcase
    end

    // Next state and outputs
    always_comb begin
        state_d         = state_q;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        bus.mem_wr_len  = 4'd0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = '0;
        bus.rsp_valid   = 2'b00;
        bus.rsp_err     = 1'b0;
        bus.rsp_data    = '0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = (sel_illegal || sel_misaligned) ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_we_q) begin
                    bus.mem_wr_en   = 1'b1;
                    bus.mem_wr_addr = cmd_addr_q;
                    bus.mem_wr_data = cmd_wdata_q;
                    bus.mem_wr_len  = 4'd1 << cmd_f3_q[1:0];
                end else begin
                    bus.mem_rd_en   = 1'b1;
                    bus.mem_rd_addr = cmd_addr_q;
                end
                state_d = RESP;
            end
            ERR: begin
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = cmd_port_q ? 2'b10 : 2'b01;
                bus.rsp_err   = cmd_err_q;
                bus.rsp_data  = (cmd_we_q || cmd_err_q) ? '0 : load_val;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_arb_ctrl
// This bench drives the arbiter with directed and randomized requests on both
// ports, and it provides a byte-array data memory for the design.
//
// A transaction-level reference model derives every cycle's expected outputs:
//   - It tracks the busy window, the round-robin pointer and an expected byte
//     image of memory.
//   - From these it predicts the accept, the memory command one cycle later
//     and the response two cycles later.
//
// Literal expectations pin the model for hand-computed cases.
// -----------------------------------------------------------------------------
module tb_dmem_arb_ctrl;
    localparam int AW = 11;
    localparam int XL = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arb_if #(.ADDR_W(AW), .XLEN(XL)) bus ();

    dmem_arb_ctrl #(.ADDR_W(AW), .XLEN(XL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory seen by the design. It is written only through the design's
    // write port.
    logic [7:0] phys_mem [0:2047] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            for (int k = 0; k < 8; k++)
                if (k < int'(bus.mem_wr_len))
                    phys_mem[11'(int'(bus.mem_wr_addr) + k)] <= bus.mem_wr_data[8*k +: 8];
        end
        if (bus.mem_rd_en) begin
            for (int k = 0; k < 8; k++)
                bus.mem_rd_data[63-8*k -: 8] <= phys_mem[11'(int'(bus.mem_rd_addr) + k)];
        end
    end

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [2:0]  f3;
        logic [63:0] wdata;
        bit          has_lit;
        logic [63:0] lit_data;
        logic        lit_err;
    } req_t;

    typedef struct {
        logic        wr_en;
        logic [10:0] wr_addr;
        logic [63:0] wr_data;
        logic [3:0]  wr_len;
        logic        rd_en;
        logic [10:0] rd_addr;
        logic [1:0]  rsp_valid;
        logic        rsp_err;
        logic [63:0] rsp_data;
    } exp_t;

    logic [7:0] ref_mem [0:2047] = '{default: 8'h00};
    exp_t slot [4];
    req_t q0 [$];
    req_t q1 [$];
    int   grant_log [$];
    bit   pres [2];
    bit   gap_en    = 1'b0;
    int   cyc       = 0;
    int   next_free = 0;
    int   last_g    = 1;
    int   hs_count  = 0;
    int   errors    = 0;
    int   checks    = 0;

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic req_t mk(bit we, int addr, int f3, logic [63:0] wd,
                                bit hl, logic [63:0] ld, bit le);
        req_t r;
        r.we = we; r.addr = 11'(addr); r.f3 = 3'(f3); r.wdata = wd;
        r.has_lit = hl; r.lit_data = ld; r.lit_err = le;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int n;
        r.f3 = 3'($urandom_range(0, 7));
        r.we = 1'($urandom_range(0, 1));
        n = 1 << r.f3[1:0];
        if ($urandom_range(0, 3) != 0) r.addr = 11'($urandom_range(0, 63));
        else                           r.addr = 11'($urandom_range(0, 2047));
        if ($urandom_range(0, 4) != 0) r.addr = r.addr & ~11'(n - 1);
        r.wdata = {$urandom, $urandom};
        r.has_lit = 1'b0; r.lit_data = '0; r.lit_err = 1'b0;
        return r;
    endfunction

    // Load value taken from the expected memory image. Byte k comes from
    // addr+k (little-endian), and the value is then extended by signedness.
    function automatic logic [63:0] ref_load(logic [10:0] a, logic [2:0] f3);
        int n = 1 << f3[1:0];
        logic [63:0] v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[11'(int'(a) + k)];
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8*n));
        return v;
    endfunction

    task automatic model_accept(req_t r, int g);
        int n = 1 << r.f3[1:0];
        bit illegal = r.we ? r.f3[2] : (r.f3 == 3'b111);
        bit mis = (int'(r.addr) % n) != 0;
        bit err = illegal || mis;
        logic [63:0] d = (err || r.we) ? 64'h0 : ref_load(r.addr, r.f3);
        int s1 = (cyc + 1) % 4;
        int s2 = (cyc + 2) % 4;
        if (!err) begin
            if (r.we) begin
                slot[s1].wr_en = 1'b1; slot[s1].wr_addr = r.addr;
                slot[s1].wr_data = r.wdata; slot[s1].wr_len = 4'(n);
            end else begin
                slot[s1].rd_en = 1'b1; slot[s1].rd_addr = r.addr;
            end
        end
        slot[s2].rsp_valid = (g == 1) ? 2'b10 : 2'b01;
        slot[s2].rsp_err   = err;
        slot[s2].rsp_data  = d;
        if (r.has_lit) chk("model_pin", {err, d}, {r.lit_err, r.lit_data});
        last_g    = g;
        next_free = cyc + 3;
        hs_count++;
    endtask

    task automatic drive();
        if (!pres[0] && q0.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) pres[0] = 1'b1;
        if (!pres[1] && q1.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) pres[1] = 1'b1;
        bus.req_we = 2'b00; bus.req_addr = '0; bus.req_funct3 = '0; bus.req_wdata = '0;
        if (pres[0]) begin
            bus.req_we[0] = q0[0].we; bus.req_addr[10:0] = q0[0].addr;
            bus.req_funct3[2:0] = q0[0].f3; bus.req_wdata[63:0] = q0[0].wdata;
        end
        if (pres[1]) begin
            bus.req_we[1] = q1[0].we; bus.req_addr[21:11] = q1[0].addr;
            bus.req_funct3[5:3] = q1[0].f3; bus.req_wdata[127:64] = q1[0].wdata;
        end
        bus.req_valid = {pres[1], pres[0]};
    endtask

    // One clock cycle. It is entered at a negedge, and it checks outputs
    // 1 time unit after the inputs change.
    task automatic tick();
        exp_t e;
        logic [1:0] v;
        logic [1:0] exp_rdy;
        int g;
        req_t r;
        drive();
        #1;
        e = slot[cyc % 4];
        slot[cyc % 4] = '{default: '0};
        v = {pres[1], pres[0]};
        exp_rdy = 2'b00;
        if (cyc >= next_free && v != 2'b00) begin
            g = (v == 2'b11) ? ((last_g == 0) ? 1 : 0) : (v[1] ? 1 : 0);
            exp_rdy = (g == 1) ? 2'b10 : 2'b01;
            if (g == 1) r = q1.pop_front(); else r = q0.pop_front();
            pres[g] = 1'b0;
            model_accept(r, g);
        end
        if (bus.req_ready != 2'b00) grant_log.push_back(bus.req_ready[1] ? 1 : 0);
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("mem_wr", {bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_len},
                      {e.wr_en, e.wr_addr, e.wr_data, e.wr_len});
        chk("mem_rd", {bus.mem_rd_en, bus.mem_rd_addr}, {e.rd_en, e.rd_addr});
        chk("rsp_ctl", {bus.rsp_valid, bus.rsp_err}, {e.rsp_valid, e.rsp_err});
        chk("rsp_data", bus.rsp_data, e.rsp_data);
        if (e.wr_en)
            for (int k = 0; k < int'(e.wr_len); k++)
                ref_mem[11'(int'(e.wr_addr) + k)] = e.wr_data[8*k +: 8];
        if (e.rsp_valid != 2'b00)
            $display("txn cycle=%0d port=%0d err=%0d data=%h", cyc,
                     e.rsp_valid[1] ? 1 : 0, e.rsp_err, bus.rsp_data);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(int maxc);
        int c = 0;
        while ((q0.size() != 0 || q1.size() != 0 || cyc < next_free) && c < maxc) begin
            tick();
            c++;
        end
        if (c >= maxc) begin
            checks++; errors++;
            $display("FAIL drain_timeout cycle=%0d actual=busy required=idle", cyc);
        end
    endtask

    initial begin
        int exp_g [4] = '{0, 1, 0, 1};
        int g0;
        int c;
        int hs0;
        bus.req_valid = 2'b00; bus.req_we = 2'b00; bus.req_addr = '0;
        bus.req_funct3 = '0; bus.req_wdata = '0;
        pres[0] = 1'b0; pres[1] = 1'b0;
        for (int i = 0; i < 4; i++) slot[i] = '{default: '0};

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", bus.req_ready, 2'b00);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, '0);
        chk("rst_wr", {bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_len}, '0);
        chk("rst_rd", {bus.mem_rd_en, bus.mem_rd_addr}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Both ports requesting from reset: grants 0,1,0,1
        g0 = grant_log.size();
        q0.push_back(mk(0, 'h000, 3, 0, 1, 64'h0, 0));
        q0.push_back(mk(0, 'h008, 3, 0, 1, 64'h0, 0));
        q1.push_back(mk(0, 'h020, 2, 0, 1, 64'h0, 0));
        q1.push_back(mk(0, 'h028, 2, 0, 1, 64'h0, 0));
        drain(60);
        for (int i = 0; i < 4; i++)
            chk("rr_order", (grant_log.size() > g0 + i) ? grant_log[g0 + i] : -1, exp_g[i]);

        // SD/LD round trip, then sized loads
        q0.push_back(mk(1, 'h010, 3, 64'h1122334455667788, 1, 64'h0, 0));
        q0.push_back(mk(0, 'h010, 3, 0, 1, 64'h1122334455667788, 0));
        q0.push_back(mk(0, 'h010, 0, 0, 1, 64'hFFFFFFFFFFFFFF88, 0));
        q0.push_back(mk(0, 'h010, 4, 0, 1, 64'h88, 0));
        q0.push_back(mk(0, 'h012, 1, 0, 1, 64'h5566, 0));
        q0.push_back(mk(0, 'h014, 2, 0, 1, 64'h11223344, 0));
        q0.push_back(mk(0, 'h010, 6, 0, 1, 64'h55667788, 0));
        // Error cases: misaligned LW/SH, illegal load and store funct3
        q0.push_back(mk(0, 'h013, 2, 0, 1, 64'h0, 1));
        q0.push_back(mk(1, 'h011, 1, 64'hFFFF, 1, 64'h0, 1));
        q0.push_back(mk(0, 'h010, 7, 0, 1, 64'h0, 1));
        q0.push_back(mk(1, 'h010, 4, 64'hFF, 1, 64'h0, 1));
        // Top byte of memory
        q0.push_back(mk(1, 'h7FF, 0, 64'hAB, 1, 64'h0, 0));
        q0.push_back(mk(0, 'h7FF, 4, 0, 1, 64'hAB, 0));
        drain(200);

        // Reset during ISSUE of a store: write dropped, no response
        q0.push_back(mk(1, 'h100, 3, 64'hDEADBEEFCAFEF00D, 0, 0, 0));
        hs0 = hs_count;
        c = 0;
        while (hs_count == hs0 && c < 20) begin tick(); c++; end
        if (hs_count == hs0) begin
            checks++; errors++;
            $display("FAIL t5_handshake_timeout cycle=%0d actual=none required=handshake", cyc);
        end
        #1;
        chk("t5_issue_wr", bus.mem_wr_en, 1'b1);
        rst = 1'b1;
        bus.req_valid = 2'b00;
        #1;
        chk("t5_rst_wr", bus.mem_wr_en, 1'b0);
        chk("t5_rst_rsp", bus.rsp_valid, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_no_rsp", bus.rsp_valid, 2'b00);
        for (int i = 0; i < 4; i++) slot[i] = '{default: '0};
        pres[0] = 1'b0; pres[1] = 1'b0;
        cyc += 3;
        next_free = cyc;
        last_g = 1;
        rst = 1'b0;
        g0 = grant_log.size();
        q0.push_back(mk(0, 'h100, 3, 0, 1, 64'h0, 0));
        q1.push_back(mk(0, 'h010, 3, 0, 1, 64'h1122334455667788, 0));
        drain(40);
        chk("t5_first_grant", (grant_log.size() > g0) ? grant_log[g0] : -1, 0);

        // Randomized traffic on both ports
        gap_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            q0.push_back(rand_req());
            q1.push_back(rand_req());
        end
        drain(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
